// File: rtl/ext_job_sequencer.sv
// Job sequencer between the register block and the external compute logic.
// Queues data-register writes, launches one job at a time, writes results back.
module ext_job_sequencer #(
    parameter int DATA_W  = 32,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      data_wr_stb,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      arm_stb,
    input  logic                      arm_val,
    input  logic                      err_clr,
    output logic [DATA_W-1:0]         ext_data,
    output logic                      ext_we,
    input  logic                      ext_done,
    input  logic [DATA_W-1:0]         ext_result,
    output logic [DATA_W-1:0]         result_out,
    output logic                      result_out_enb,
    output logic                      busy,
    output logic                      armed,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      q_full,
    output logic                      ovf_err,
    output logic                      tmo_err
);

    // state | meaning
    // IDLE  | waiting for armed and a queued job; pops the head on exit
    // ISSUE | ext_we high for this single cycle, timeout counter cleared
    // WAIT  | waiting for ext_done or timeout
    // WB    | result_out_enb high for one cycle
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [QDEPTH];
    logic [DATA_W-1:0] mem_d [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0] ext_data_q, ext_data_d, result_q, result_d;
    logic              armed_q, armed_d, ext_we_q, ext_we_d, enb_q, enb_d;
    logic              busy_q, busy_d, full_q, full_d, ovf_q, ovf_d, tmo_q, tmo_d;
    logic              full_now, pop, push, tmo_set;

    always_comb begin
        armed_d    = arm_stb ? arm_val : armed_q;
        full_now   = (count_q == CW'(QDEPTH));
        pop        = (state_q == IDLE) && armed_q && (count_q != '0);
        // a pop in the same cycle frees the slot, so a full queue still accepts
        push       = data_wr_stb && (!full_now || pop);

        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        ext_data_d = ext_data_q;
        result_d   = result_q;
        tmo_set    = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    ext_data_d = mem_q[rd_ptr_q];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (ext_done) begin
                    result_d = ext_result;
                    state_d  = WB;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ext_we_d = (state_d == ISSUE);
        enb_d    = (state_d == WB);
        busy_d   = (state_d != IDLE);
        full_d   = (count_d == CW'(QDEPTH));
        // set beats clear when both land in the same cycle
        ovf_d    = (data_wr_stb && full_now && !pop) || (ovf_q && !err_clr);
        tmo_d    = tmo_set || (tmo_q && !err_clr);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= IDLE;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_cnt_q  <= '0;
            ext_data_q <= '0;
            result_q   <= '0;
            armed_q    <= 1'b0;
            ext_we_q   <= 1'b0;
            enb_q      <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ext_data_q <= ext_data_d;
            result_q   <= result_d;
            armed_q    <= armed_d;
            ext_we_q   <= ext_we_d;
            enb_q      <= enb_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign ext_data       = ext_data_q;
    assign ext_we         = ext_we_q;
    assign result_out     = result_q;
    assign result_out_enb = enb_q;
    assign busy           = busy_q;
    assign armed          = armed_q;
    assign q_count        = count_q;
    assign q_full         = full_q;
    assign ovf_err        = ovf_q;
    assign tmo_err        = tmo_q;

endmodule

// File: tb/tb_ext_job_sequencer.sv
// Directed bench for ext_job_sequencer: responder model plus issue/writeback
// scoreboards checked whenever the DUT launches a job or writes a result back.
module tb_ext_job_sequencer;

    localparam int DATA_W = 32;

    logic              hclk, hresetn;
    logic              data_wr_stb, arm_stb, arm_val, err_clr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] ext_data, ext_result, result_out;
    logic              ext_we, ext_done, result_out_enb, busy, armed;
    logic [2:0]        q_count;
    logic              q_full, ovf_err, tmo_err;

    ext_job_sequencer #(.DATA_W(DATA_W), .QDEPTH(4), .TIMEOUT(255)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .data_wr_stb(data_wr_stb), .data_in(data_in),
        .arm_stb(arm_stb), .arm_val(arm_val), .err_clr(err_clr),
        .ext_data(ext_data), .ext_we(ext_we),
        .ext_done(ext_done), .ext_result(ext_result),
        .result_out(result_out), .result_out_enb(result_out_enb),
        .busy(busy), .armed(armed), .q_count(q_count), .q_full(q_full),
        .ovf_err(ovf_err), .tmo_err(tmo_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int wb_cnt = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    int resp_dly = 1;
    logic [DATA_W-1:0] resp_add = 32'h11;
    logic [DATA_W-1:0] skip_val = 32'hDEAD_0000;
    logic [DATA_W-1:0] exp_issue[$];
    logic [DATA_W-1:0] exp_wb[$];

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // External logic model: answers each launch resp_dly cycles later with data+resp_add.
    initial begin
        logic [DATA_W-1:0] d;
        ext_done   = 1'b0;
        ext_result = '0;
        forever begin
            @(negedge hclk);
            if (ext_we === 1'b1 && ext_data !== skip_val) begin
                d = ext_data;
                repeat (resp_dly) @(posedge hclk);
                #1;
                ext_done   = 1'b1;
                ext_result = d + resp_add;
                done_cyc   = cyc;
                @(posedge hclk);
                #1;
                ext_done   = 1'b0;
            end
        end
    end

    always @(negedge hclk) begin
        if (ext_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
            check("issue_expected", exp_issue.size() > 0, 1'b1);
            if (exp_issue.size() > 0) check("ext_data", ext_data, exp_issue.pop_front());
        end
        if (result_out_enb === 1'b1) begin
            wb_cnt++;
            check("wb_latency", cyc, done_cyc + 1);
            check("wb_expected", exp_wb.size() > 0, 1'b1);
            if (exp_wb.size() > 0) check("result_out", result_out, exp_wb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input bit issues, input bit writes_back);
        data_wr_stb = 1'b1;
        data_in     = d;
        if (issues) exp_issue.push_back(d);
        if (writes_back) exp_wb.push_back(d + resp_add);
        tick(1);
        data_wr_stb = 1'b0;
    endtask

    task automatic arm(input logic v);
        arm_stb = 1'b1;
        arm_val = v;
        tick(1);
        arm_stb = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (!(busy === 1'b0 && q_count === 3'd0) && n < budget);
        check(tag, (busy === 1'b0 && q_count === 3'd0), 1'b1);
    endtask

    task automatic wait_we(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (ext_we !== 1'b1 && n < budget);
        check(tag, ext_we, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ext_data"}, ext_data, 0);
        check({tag, "_ext_we"}, ext_we, 0);
        check({tag, "_result_out"}, result_out, 0);
        check({tag, "_result_enb"}, result_out_enb, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_q_count"}, q_count, 0);
        check({tag, "_q_full"}, q_full, 0);
        check({tag, "_ovf_err"}, ovf_err, 0);
        check({tag, "_tmo_err"}, tmo_err, 0);
    endtask

    initial begin
        int we_before, wb_before, n;
        hresetn     = 1'b0;
        data_wr_stb = 1'b0;
        data_in     = '0;
        arm_stb     = 1'b0;
        arm_val     = 1'b0;
        err_clr     = 1'b0;
        tick(3);
        @(negedge hclk);
        check_reset_vals("por");
        tick(1);
        hresetn = 1'b1;
        tick(2);

        // single job launched only once armed
        resp_add = 32'h11;
        resp_dly = 1;
        push(32'h11, 1, 1);
        @(negedge hclk);
        check("t1_q_count", q_count, 1);
        tick(4);
        check("t1_no_we_disarmed", we_cnt, 0);
        arm(1'b1);
        @(negedge hclk);
        check("t1_armed", armed, 1);
        check("t1_we_not_yet", ext_we, 0);
        tick(1);
        @(negedge hclk);
        check("t1_we_2cyc", ext_we, 1);
        check("t1_ext_data", ext_data, 32'h11);
        wait_idle("t1_idle", 50);
        check("t1_wb_cnt", wb_cnt, 1);
        check("t1_result", result_out, 32'h22);

        // six back-to-back pushes: the first is popped at once, so the sixth overflows
        resp_add = 32'h1;
        resp_dly = 2;
        for (int i = 1; i <= 5; i++) push(32'hA0 + i, 1, 1);
        push(32'hA6, 0, 0);
        @(negedge hclk);
        check("t2_ovf_set", ovf_err, 1);
        check("t2_q_count", q_count, 4);
        check("t2_q_full", q_full, 1);
        wait_idle("t2_idle", 200);
        check("t2_wb_cnt", wb_cnt, 6);
        check("t2_ovf_sticky", ovf_err, 1);
        pulse_err_clr();
        @(negedge hclk);
        check("t2_ovf_clr", ovf_err, 0);

        // full queue: push in the same cycle as the pop is accepted
        arm(1'b0);
        we_before = we_cnt;
        for (int i = 1; i <= 4; i++) push(32'hB0 + i, 1, 1);
        @(negedge hclk);
        check("t3_full_count", q_count, 4);
        check("t3_full_flag", q_full, 1);
        check("t3_no_we", we_cnt, we_before);
        arm(1'b1);
        push(32'hB5, 1, 1);
        @(negedge hclk);
        check("t3_pop_push_count", q_count, 4);
        check("t3_pop_push_full", q_full, 1);
        check("t3_pop_push_ovf", ovf_err, 0);
        check("t3_issue", ext_we, 1);
        wait_idle("t3_idle", 200);
        check("t3_wb_cnt", wb_cnt, 11);

        // timeout: C1 never answered, C2 follows normally
        skip_val = 32'hC1;
        push(32'hC1, 1, 0);
        push(32'hC2, 1, 1);
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (tmo_err !== 1'b1 && n < 400);
        check("t4_tmo_set", tmo_err, 1);
        check("t4_tmo_cycle", cyc - last_we_cyc, 256);
        check("t4_idle_after_tmo", busy, 0);
        check("t4_no_wb", wb_cnt, 11);
        check("t4_result_kept", result_out, 32'hB6);
        wait_idle("t4_idle", 100);
        check("t4_next_wb", wb_cnt, 12);
        check("t4_tmo_sticky", tmo_err, 1);
        pulse_err_clr();
        @(negedge hclk);
        check("t4_tmo_clr", tmo_err, 0);

        // disarm while waiting: current job completes, the rest stay queued
        arm(1'b0);
        resp_dly = 4;
        push(32'hD1, 1, 1);
        push(32'hD2, 1, 1);
        push(32'hD3, 1, 1);
        arm(1'b1);
        wait_we("t5_issue", 20);
        check("t5_q_after_pop", q_count, 2);
        tick(1);
        arm(1'b0);
        n = 0;
        do begin
            @(negedge hclk);
            n++;
        end while (busy !== 1'b0 && n < 50);
        check("t5_idle", busy, 0);
        check("t5_wb_done", wb_cnt, 13);
        check("t5_q_kept", q_count, 2);
        check("t5_disarmed", armed, 0);
        we_before = we_cnt;
        tick(10);
        check("t5_no_we", we_cnt, we_before);
        arm(1'b1);
        wait_idle("t5_drain", 100);
        check("t5_wb_all", wb_cnt, 15);

        // reset in the middle of WAIT with three jobs still queued
        arm(1'b0);
        resp_dly = 8;
        for (int i = 1; i <= 4; i++) push(32'hE0 + i, 1, 1);
        err_clr = 1'b1;
        push(32'hE5, 0, 0);
        err_clr = 1'b0;
        @(negedge hclk);
        check("t6_set_beats_clr", ovf_err, 1);
        arm(1'b1);
        wait_we("t6_issue", 20);
        check("t6_q_count", q_count, 3);
        tick(2);
        hresetn = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        exp_issue.delete();
        exp_wb.delete();
        tick(2);
        hresetn = 1'b1;
        wb_before = wb_cnt;
        tick(12);
        check("t6_late_done_no_wb", wb_cnt, wb_before);
        check("t6_result_zero", result_out, 0);
        check("t6_busy", busy, 0);
        check("t6_q_empty", q_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
